interconnect_2_slaves: RTL and testbench
========================================

INTERCONNECT_2_SLAVES -- requirements
Module: interconnect_2_slaves

Interface
REQ-001 The block SHALL take parameter S0_BASE, default 32'h0000_0000, slave 0 base address.
REQ-002 The block SHALL take parameter S0_MASK, default 32'hFF00_0000, slave 0 decode mask.
REQ-003 The block SHALL take parameter S1_BASE, default 32'h0100_0000, slave 1 base address.
REQ-004 The block SHALL take parameter S1_MASK, default 32'hFF00_0000, slave 1 decode mask.
REQ-005 The block SHALL take parameter TIMEOUT_CYCLES, default 256, no-ack abort limit.
REQ-006 The block SHALL have these ports, one per line:
 clk  in  1  single clock, all logic on rising edge
 rst_n  in  1  synchronous, active-low reset
 i_m_we, i_m_cyc, i_m_stb  in  1 each  master controls
 i_m_sel  in  4  master byte select
 i_m_adr, i_m_dat  in  32 each  master address, write data
 o_m_ack  out  1  ack to master
 o_m_dat  out  32  read data to master
 o_m_int  out  1  interrupt to master
 o_sN_we, o_sN_stb, o_sN_cyc  out  1 each  slave N controls (N=0,1)
 o_sN_sel  out  4;  o_sN_adr, o_sN_dat  out  32 each  slave N sel/address/write data
 i_sN_dat  in  32;  i_sN_ack, i_sN_int  in  1 each  slave N read data/ack/interrupt
 o_err  out  1  one-cycle pulse on an unmapped or timed-out transfer

Function
REQ-007 Slave N SHALL hit when (i_m_adr & SN_MASK) == (SN_BASE & SN_MASK); if both hit, slave 0 SHALL win.
REQ-008 The FSM SHALL have states IDLE, ACTIVE, ERR.
REQ-009 In IDLE with i_m_cyc && i_m_stb: on a hit, latch the slave index and go to ACTIVE; with no hit, go to ERR.
REQ-010 In ACTIVE, the selected slave's we/stb/cyc/sel/adr/dat SHALL follow the master combinationally.
REQ-011 The unselected slave's outputs, and all slave outputs outside ACTIVE, SHALL be 0.
REQ-012 In ACTIVE, o_m_ack and o_m_dat SHALL equal the selected slave's ack and data combinationally, giving first-strobe latency of one cycle plus slave latency.
REQ-013 In ACTIVE, the selected slave's ack SHALL return the FSM to IDLE; each transfer is re-decoded.
REQ-014 In ACTIVE, i_m_cyc low with no ack SHALL abort to IDLE with no ack to the master.
REQ-015 An ack from an unselected slave, or any slave ack in IDLE, SHALL be ignored.
REQ-016 ERR SHALL last one cycle: o_m_ack=1, o_m_dat=ERR_DATA (32'hDEAD_BEEF), o_err=1; then go to IDLE.
REQ-017 Outside ACTIVE and ERR, o_m_ack SHALL be 0 and o_m_dat SHALL be 0.
REQ-018 o_m_int SHALL be registered i_s0_int | i_s1_int, one cycle latency.

Reset
REQ-019 With rst_n low at a clock edge: state=IDLE, o_m_int=0, o_err=0, timeout counter=0; combinational outputs SHALL then read 0.
REQ-020 Reset asserted mid-transfer SHALL drop the slave strobe/cyc on the next cycle, with no ack issued.

Configuration
REQ-021 With INTERCONNECT_TIMEOUT_EN defined, a counter SHALL clear on entry to ACTIVE and increment each ACTIVE cycle without ack.
REQ-022 With INTERCONNECT_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 SHALL force ERR; that cycle the slave strobe/cyc SHALL be 0.
REQ-023 Without INTERCONNECT_TIMEOUT_EN, no counter SHALL exist and ACTIVE SHALL wait indefinitely for an ack or a cyc drop.

Structure
REQ-024 Package interconnect_pkg SHALL hold the state encoding, the ERR_DATA constant and the slave index type.
REQ-025 Decode SHALL be a combinational sub-module interconnect_addr_decode, outputting hit0, hit1 and a no-hit flag.

Verification
REQ-026 Write to 32'h0000_0010, data 32'h1234_5678, s0 ack after 2 cycles -> o_s0_stb high 2 cycles, o_m_ack 1 pulse, s1 outputs 0.
REQ-027 Read from 32'h0100_0004, s1 returns 32'hCAFE_F00D -> o_m_dat=32'hCAFE_F00D with ack; state back to IDLE next cycle.
REQ-028 Access to 32'h0200_0000 -> ack and o_err pulse one cycle after strobe, o_m_dat=32'hDEAD_BEEF, no slave strobed.
REQ-029 INTERCONNECT_TIMEOUT_EN with TIMEOUT_CYCLES=8, s0 never acks -> ERR after 8 ACTIVE cycles, ack with DEAD_BEEF; without the macro, no ack after 100 cycles.
REQ-030 rst_n low during an ACTIVE s1 transfer -> next cycle all slave outputs 0, no o_m_ack; a later transfer works normally.
REQ-031 Base/mask overlap both set to 32'h0 with i_s1_int pulsed -> slave 0 selected; o_m_int pulses one cycle after i_s1_int.

Source files
------------

// File: rtl/interconnect_pkg.sv
// -----------------------------------------------------------------------------
// interconnect_pkg
// Shared definitions for the two-slave bus interconnect:
//   state_t      FSM state encoding (IDLE / ACTIVE / ERR)
//   slave_idx_t  index of the slave latched for the current transfer
//   ERR_DATA     read data returned to the master on an error response
//   addr_hit()   base/mask address match used by the decoder
// -----------------------------------------------------------------------------
package interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  typedef enum logic {
    SLV_0 = 1'b0,
    SLV_1 = 1'b1
  } slave_idx_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // A slave claims an address when every bit selected by its mask matches
  // the corresponding bit of its base.
  function automatic logic addr_hit(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return ((adr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/interconnect_addr_decode.sv
// -----------------------------------------------------------------------------
// interconnect_addr_decode
// Purely combinational address decoder for the two-slave interconnect.
// Both hit flags are raw matches; the slave-0 priority on overlapping
// windows is applied by the caller.
//
// Ports:
//   i_adr     in  32  master address
//   o_hit0    out  1  address falls in the slave 0 window
//   o_hit1    out  1  address falls in the slave 1 window
//   o_no_hit  out  1  address falls in neither window
// -----------------------------------------------------------------------------
module interconnect_addr_decode
  import interconnect_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFF00_0000,
  parameter logic [31:0] S1_BASE = 32'h0100_0000,
  parameter logic [31:0] S1_MASK = 32'hFF00_0000
) (
  input  logic [31:0] i_adr,
  output logic        o_hit0,
  output logic        o_hit1,
  output logic        o_no_hit
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0   = addr_hit(i_adr, S0_BASE, S0_MASK);
  assign w_hit1   = addr_hit(i_adr, S1_BASE, S1_MASK);

  assign o_hit0   = w_hit0;
  assign o_hit1   = w_hit1;
  assign o_no_hit = ~(w_hit0 | w_hit1);

endmodule

// File: rtl/interconnect_2_slaves.sv
// -----------------------------------------------------------------------------
// interconnect_2_slaves
// Single-master, two-slave bus interconnect. Each strobe is decoded in IDLE;
// a hit routes the master onto the chosen slave for the rest of the transfer,
// a miss produces a one-cycle error response (ack + ERR_DATA + o_err).
// Slave interrupts are OR-ed and registered towards the master.
//
// Optional feature: define INTERCONNECT_TIMEOUT_EN to enable the no-ack
// watchdog. When enabled, a transfer that stays in ACTIVE without an ack
// for TIMEOUT_CYCLES cycles is turned into an error response. When not
// defined, ACTIVE waits for an ack or a cyc drop indefinitely.
//
// Ports:
//   clk                      in   1  clock, rising edge
//   rst_n                    in   1  synchronous active-low reset
//   i_m_we/cyc/stb           in   1  master controls
//   i_m_sel                  in   4  master byte select
//   i_m_adr, i_m_dat         in  32  master address / write data
//   o_m_ack                  out  1  ack to master
//   o_m_dat                  out 32  read data to master
//   o_m_int                  out  1  registered OR of slave interrupts
//   o_sN_we/stb/cyc          out  1  slave N controls (N = 0, 1)
//   o_sN_sel                 out  4  slave N byte select
//   o_sN_adr, o_sN_dat       out 32  slave N address / write data
//   i_sN_dat                 in  32  slave N read data
//   i_sN_ack, i_sN_int       in   1  slave N ack / interrupt
//   o_err                    out  1  pulse on unmapped or timed-out transfer
//
// State table:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no transfer; decode the next cyc&stb
//   ST_ACTIVE  | master routed to r_sel, waiting for its ack
//   ST_ERR     | one-cycle error response to the master
// -----------------------------------------------------------------------------
module interconnect_2_slaves
  import interconnect_pkg::*;
#(
  parameter logic [31:0] S0_BASE        = 32'h0000_0000,
  parameter logic [31:0] S0_MASK        = 32'hFF00_0000,
  parameter logic [31:0] S1_BASE        = 32'h0100_0000,
  parameter logic [31:0] S1_MASK        = 32'hFF00_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_m_we,
  input  logic        i_m_cyc,
  input  logic        i_m_stb,
  input  logic [3:0]  i_m_sel,
  input  logic [31:0] i_m_adr,
  input  logic [31:0] i_m_dat,
  output logic        o_m_ack,
  output logic [31:0] o_m_dat,
  output logic        o_m_int,

  output logic        o_s0_we,
  output logic        o_s0_stb,
  output logic        o_s0_cyc,
  output logic [3:0]  o_s0_sel,
  output logic [31:0] o_s0_adr,
  output logic [31:0] o_s0_dat,
  input  logic [31:0] i_s0_dat,
  input  logic        i_s0_ack,
  input  logic        i_s0_int,

  output logic        o_s1_we,
  output logic        o_s1_stb,
  output logic        o_s1_cyc,
  output logic [3:0]  o_s1_sel,
  output logic [31:0] o_s1_adr,
  output logic [31:0] o_s1_dat,
  input  logic [31:0] i_s1_dat,
  input  logic        i_s1_ack,
  input  logic        i_s1_int,

  output logic        o_err
);

  state_t      r_state;
  state_t      w_state_nxt;
  slave_idx_t  r_sel;
  slave_idx_t  w_sel_nxt;
  logic        r_int;

  logic        w_hit0;
  logic        w_hit1;
  logic        w_no_hit;
  logic        w_req;
  logic        w_sel_ack;
  logic [31:0] w_sel_dat;
  logic        w_timeout;

  interconnect_addr_decode #(
    .S0_BASE (S0_BASE),
    .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE),
    .S1_MASK (S1_MASK)
  ) u_decode (
    .i_adr    (i_m_adr),
    .o_hit0   (w_hit0),
    .o_hit1   (w_hit1),
    .o_no_hit (w_no_hit)
  );

  assign w_req     = i_m_cyc & i_m_stb;
  assign w_sel_ack = (r_sel == SLV_0) ? i_s0_ack : i_s1_ack;
  assign w_sel_dat = (r_sel == SLV_0) ? i_s0_dat : i_s1_dat;

`ifdef INTERCONNECT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Held at zero outside ACTIVE so every transfer starts its count from 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != ST_ACTIVE) begin
      r_cnt <= '0;
    end else if (!w_sel_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_ACTIVE) && (r_cnt == CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= SLV_0;
      r_int   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_int   <= i_s0_int | i_s1_int;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_no_hit) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_ACTIVE;
            // slave 0 wins when the windows overlap
            w_sel_nxt   = w_hit0 ? SLV_0 : SLV_1;
          end
        end
      end
      ST_ACTIVE: begin
        // A cyc drop aborts silently; the watchdog outranks a late ack
        // because the slave strobe is already withdrawn in that cycle.
        if (!i_m_cyc) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end else if (w_sel_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_s0_we  = 1'b0;
    o_s0_stb = 1'b0;
    o_s0_cyc = 1'b0;
    o_s0_sel = '0;
    o_s0_adr = '0;
    o_s0_dat = '0;
    o_s1_we  = 1'b0;
    o_s1_stb = 1'b0;
    o_s1_cyc = 1'b0;
    o_s1_sel = '0;
    o_s1_adr = '0;
    o_s1_dat = '0;
    o_m_ack  = 1'b0;
    o_m_dat  = '0;
    o_err    = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (r_sel == SLV_0) begin
          o_s0_we  = i_m_we;
          o_s0_stb = i_m_stb & ~w_timeout;
          o_s0_cyc = i_m_cyc & ~w_timeout;
          o_s0_sel = i_m_sel;
          o_s0_adr = i_m_adr;
          o_s0_dat = i_m_dat;
        end else begin
          o_s1_we  = i_m_we;
          o_s1_stb = i_m_stb & ~w_timeout;
          o_s1_cyc = i_m_cyc & ~w_timeout;
          o_s1_sel = i_m_sel;
          o_s1_adr = i_m_adr;
          o_s1_dat = i_m_dat;
        end
        o_m_ack = w_sel_ack & ~w_timeout;
        o_m_dat = w_sel_dat;
      end
      ST_ERR: begin
        o_m_ack = 1'b1;
        o_m_dat = ERR_DATA;
        o_err   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_m_int = r_int;

endmodule

// File: tb/tb_interconnect_2_slaves.sv
// -----------------------------------------------------------------------------
// tb_interconnect_2_slaves
// Transaction-level bench: each transfer is described by address, slave
// latency and an optional abort point; the expected bus picture for every
// cycle is derived from the address windows and those transfer parameters.
// A second instance with fully overlapping windows covers slave-0 priority.
// -----------------------------------------------------------------------------
module tb_interconnect_2_slaves;

  localparam logic [31:0] S0_BASE = 32'h0000_0000;
  localparam logic [31:0] S0_MASK = 32'hFF00_0000;
  localparam logic [31:0] S1_BASE = 32'h0100_0000;
  localparam logic [31:0] S1_MASK = 32'hFF00_0000;
  localparam int          TO_CYC  = 8;
  localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_we, m_cyc, m_stb;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_wdat;
  logic        m_ack;
  logic [31:0] m_rdat;
  logic        m_int, err;
  logic        s0_we, s0_stb, s0_cyc, s1_we, s1_stb, s1_cyc;
  logic [3:0]  s0_sel, s1_sel;
  logic [31:0] s0_adr, s0_wdat, s1_adr, s1_wdat;
  logic [31:0] s0_rdat, s1_rdat;
  logic        s0_ack, s0_int, s1_ack, s1_int;

  logic        ov_m_ack, ov_m_int, ov_err;
  logic [31:0] ov_m_rdat;
  logic        ov_s0_we, ov_s0_stb, ov_s0_cyc, ov_s1_we, ov_s1_stb, ov_s1_cyc;
  logic [3:0]  ov_s0_sel, ov_s1_sel;
  logic [31:0] ov_s0_adr, ov_s0_wdat, ov_s1_adr, ov_s1_wdat;

  int n_total = 0;
  int n_bad   = 0;

  logic [70:0] e_s0, e_s1;
  logic [33:0] e_m;
  logic        e_int;

  always #5 clk = ~clk;

  interconnect_2_slaves #(
    .S0_BASE (S0_BASE), .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE), .S1_MASK (S1_MASK),
    .TIMEOUT_CYCLES (TO_CYC)
  ) u_dut (
    .clk (clk), .rst_n (rst_n),
    .i_m_we (m_we), .i_m_cyc (m_cyc), .i_m_stb (m_stb), .i_m_sel (m_sel),
    .i_m_adr (m_adr), .i_m_dat (m_wdat),
    .o_m_ack (m_ack), .o_m_dat (m_rdat), .o_m_int (m_int),
    .o_s0_we (s0_we), .o_s0_stb (s0_stb), .o_s0_cyc (s0_cyc), .o_s0_sel (s0_sel),
    .o_s0_adr (s0_adr), .o_s0_dat (s0_wdat),
    .i_s0_dat (s0_rdat), .i_s0_ack (s0_ack), .i_s0_int (s0_int),
    .o_s1_we (s1_we), .o_s1_stb (s1_stb), .o_s1_cyc (s1_cyc), .o_s1_sel (s1_sel),
    .o_s1_adr (s1_adr), .o_s1_dat (s1_wdat),
    .i_s1_dat (s1_rdat), .i_s1_ack (s1_ack), .i_s1_int (s1_int),
    .o_err (err)
  );

  interconnect_2_slaves #(
    .S0_BASE (32'h0), .S0_MASK (32'h0),
    .S1_BASE (32'h0), .S1_MASK (32'h0)
  ) u_ovl (
    .clk (clk), .rst_n (rst_n),
    .i_m_we (m_we), .i_m_cyc (m_cyc), .i_m_stb (m_stb), .i_m_sel (m_sel),
    .i_m_adr (m_adr), .i_m_dat (m_wdat),
    .o_m_ack (ov_m_ack), .o_m_dat (ov_m_rdat), .o_m_int (ov_m_int),
    .o_s0_we (ov_s0_we), .o_s0_stb (ov_s0_stb), .o_s0_cyc (ov_s0_cyc), .o_s0_sel (ov_s0_sel),
    .o_s0_adr (ov_s0_adr), .o_s0_dat (ov_s0_wdat),
    .i_s0_dat (s0_rdat), .i_s0_ack (s0_ack), .i_s0_int (s0_int),
    .o_s1_we (ov_s1_we), .o_s1_stb (ov_s1_stb), .o_s1_cyc (ov_s1_cyc), .o_s1_sel (ov_s1_sel),
    .o_s1_adr (ov_s1_adr), .o_s1_dat (ov_s1_wdat),
    .i_s1_dat (s1_rdat), .i_s1_ack (s1_ack), .i_s1_int (s1_int),
    .o_err (ov_err)
  );

  task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if ((a & S0_MASK) == (S0_BASE & S0_MASK)) return 0;
    if ((a & S1_MASK) == (S1_BASE & S1_MASK)) return 1;
    return -1;
  endfunction

  // what a routed slave should see: the master bus, with stb/cyc optionally forced low
  function automatic logic [70:0] mbus(input logic en);
    return {m_we, m_stb & en, m_cyc & en, m_sel, m_adr, m_wdat};
  endfunction

  task automatic drive_rand();
    s0_int  = 1'($urandom);
    s1_int  = 1'($urandom);
    s0_rdat = $urandom;
    s1_rdat = $urandom;
    s0_ack  = 1'($urandom);
    s1_ack  = 1'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    check("s0_bus", {s0_we, s0_stb, s0_cyc, s0_sel, s0_adr, s0_wdat}, e_s0);
    check("s1_bus", {s1_we, s1_stb, s1_cyc, s1_sel, s1_adr, s1_wdat}, e_s1);
    check("m_resp", {m_ack, m_rdat, err}, {37'd0, e_m});
    check("m_int", m_int, e_int);
  endtask

  task automatic advance();
    @(posedge clk);
    e_int = rst_n ? (s0_int | s1_int) : 1'b0;
    #1;
  endtask

  task automatic expect_quiet();
    e_s0 = '0;
    e_s1 = '0;
    e_m  = '0;
  endtask

  // lat: strobe cycle in which the slave acks (0 = never)
  // abort_at: ACTIVE cycle in which the master drops cyc (0 = never)
  task automatic xfer(input logic [31:0] adr, input logic we, input int lat,
                      input int abort_at, input logic [31:0] wdat, input logic [31:0] rdat);
    int tgt;
    bit done;
    tgt    = decode(adr);
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
    m_adr  = adr;
    m_we   = we;
    m_sel  = 4'($urandom);
    m_wdat = wdat;
    drive_rand();
    expect_quiet();
    step();
    advance();
    if (tgt < 0) begin
      drive_rand();
      e_s0 = '0;
      e_s1 = '0;
      e_m  = {1'b1, ERR_DAT, 1'b1};
      step();
      advance();
    end else begin
      done = 1'b0;
      for (int k = 1; !done && k <= 150; k++) begin
        logic to;
        logic ack;
        logic [31:0] d;
        drive_rand();
        to = 1'b0;
`ifdef INTERCONNECT_TIMEOUT_EN
        to = (k == TO_CYC);
`endif
        ack = (lat != 0) && (k == lat);
        if (k == abort_at) begin
          m_cyc = 1'b0;
          m_stb = 1'b0;
          ack   = 1'b0;
        end
        if (tgt == 0) begin
          s0_ack  = ack;
          s0_rdat = rdat;
          d       = rdat;
          e_s0    = mbus(!to);
          e_s1    = '0;
        end else begin
          s1_ack  = ack;
          s1_rdat = rdat;
          d       = rdat;
          e_s1    = mbus(!to);
          e_s0    = '0;
        end
        e_m = {ack && !to, d, 1'b0};
        step();
        advance();
        if (ack || k == abort_at) begin
          done = 1'b1;
        end else if (to) begin
          drive_rand();
          e_s0 = '0;
          e_s1 = '0;
          e_m  = {1'b1, ERR_DAT, 1'b1};
          step();
          advance();
          done = 1'b1;
        end
      end
    end
    m_cyc = 1'b0;
    m_stb = 1'b0;
    drive_rand();
    expect_quiet();
    step();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    int lat;
    int ab;
    logic [31:0] adr;

    rst_n = 1'b0;
    m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_sel = '0; m_adr = '0; m_wdat = '0;
    s0_rdat = '0; s1_rdat = '0; s0_ack = 1'b0; s1_ack = 1'b0; s0_int = 1'b0; s1_int = 1'b0;
    e_int = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset held with a request pending: everything quiet
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_0010;
    drive_rand();
    expect_quiet();
    e_int = 1'b0;
    step();
    advance();
    rst_n = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b0;
    drive_rand();
    expect_quiet();
    step();
    advance();

    // write to slave 0, ack in second strobe cycle
    xfer(32'h0000_0010, 1'b1, 2, 0, 32'h1234_5678, $urandom);
    // read from slave 1
    xfer(32'h0100_0004, 1'b0, 1, 0, $urandom, 32'hCAFE_F00D);
    // unmapped
    xfer(32'h0200_0000, 1'b0, 1, 0, $urandom, $urandom);
    // slave never acks: watchdog error, or master gives up after 100 cycles
    xfer(32'h0000_0100, 1'b0, 0, 101, $urandom, $urandom);

    // reset in the middle of a slave-1 transfer
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0100_0008; m_we = 1'b1;
    m_sel = 4'($urandom); m_wdat = $urandom;
    drive_rand();
    expect_quiet();
    step();
    advance();
    drive_rand();
    s1_ack = 1'b0;
    e_s0 = '0; e_s1 = mbus(1'b1); e_m = {1'b0, s1_rdat, 1'b0};
    step();
    advance();
    rst_n = 1'b0;
    drive_rand();
    s1_ack = 1'b0;
    e_s0 = '0; e_s1 = mbus(1'b1); e_m = {1'b0, s1_rdat, 1'b0};
    step();
    advance();
    drive_rand();
    expect_quiet();
    step();
    advance();
    rst_n = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b0;
    drive_rand();
    expect_quiet();
    step();
    advance();
    xfer(32'h0100_0020, 1'b0, 3, 0, $urandom, $urandom);

    // fully overlapping windows on u_ovl: slave 0 must win; s1 interrupt pulse
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0300_0000; m_we = 1'b0;
    drive_rand();
    s0_int = 1'b0; s1_int = 1'b1; s0_ack = 1'b0; s1_ack = 1'b0;
    expect_quiet();
    step();
    check("ov_idle_stb", {ov_s0_stb, ov_s1_stb}, 2'b00);
    advance();
    drive_rand();
    s0_int = 1'b0; s1_int = 1'b0; s0_ack = 1'b1; s1_ack = 1'b0;
    e_s0 = '0; e_s1 = '0; e_m = {1'b1, ERR_DAT, 1'b1};
    step();
    check("ov_sel", {ov_s0_stb, ov_s0_cyc, ov_s1_stb, ov_s1_cyc, ov_m_ack}, 5'b11001);
    check("ov_dat", ov_m_rdat, s0_rdat);
    check("ov_int_set", ov_m_int, 1'b1);
    advance();
    m_cyc = 1'b0; m_stb = 1'b0;
    drive_rand();
    s0_int = 1'b0; s1_int = 1'b0;
    expect_quiet();
    step();
    check("ov_int_clr", ov_m_int, 1'b0);
    check("ov_idle", {ov_s0_stb, ov_s1_stb, ov_m_ack}, 3'b000);
    advance();

    // randomized transfers
    repeat (60) begin
      kind = int'($urandom_range(0, 2));
      case (kind)
        0:       adr = {8'h00, 24'($urandom)};
        1:       adr = {8'h01, 24'($urandom)};
        default: adr = {8'($urandom_range(2, 255)), 24'($urandom)};
      endcase
      lat = int'($urandom_range(1, 6));
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : 0;
      xfer(adr, 1'($urandom), lat, ab, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
